// File: rtl/fetch_queue_unit_pkg.sv
// Shared fetch types: FSM states, MIPS branch opcodes, queue entry layout.
// Used by fetch_queue_unit and fetch_bht (BHT built only with FETCH_BHT_EN).
package fetch_queue_unit_pkg;

    localparam int XLEN  = 32;
    localparam int CTR_W = 2;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]  instr;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  pc4;
        logic             pred;
        logic [CTR_W-1:0] ctr;
    } fetch_entry_t;

    function automatic logic is_cond_branch(input logic [XLEN-1:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        return (op == OP_REGIMM) || ((op >= OP_BEQ) && (op <= OP_BGTZ));
    endfunction

endpackage

// File: rtl/fetch_bht.sv
// Branch history table of two-bit saturating counters.
// Lookups are combinational and see the value before a same-cycle update.
module fetch_bht
    import fetch_queue_unit_pkg::*;
#(
    parameter int BHT_BITS = 6
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [BHT_BITS-1:0] lookup_idx,
    input  logic                update_en,
    input  logic [BHT_BITS-1:0] update_idx,
    input  logic                taken,
    output logic [CTR_W-1:0]    lookup_ctr
);

    localparam int N = 1 << BHT_BITS;

    logic [CTR_W-1:0] ctr_q [N];

    assign lookup_ctr = ctr_q[lookup_idx];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < N; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (update_en) begin
            if (taken && (ctr_q[update_idx] != 2'b11)) begin
                ctr_q[update_idx] <= ctr_q[update_idx] + 2'd1;
            end else if (!taken && (ctr_q[update_idx] != 2'b00)) begin
                ctr_q[update_idx] <= ctr_q[update_idx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// IF-side fetch unit: PC generation, single-outstanding fetch, head queue.
// Optional branch prediction is enabled with the FETCH_BHT_EN macro.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int          DEPTH    = 2,
    parameter int          BHT_BITS = 6
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FLUSH,
    input  logic [31:0] Redirect_Addr_IN,
    input  logic        STALL,
    output logic        Mem_Req_OUT,
    output logic [31:0] Mem_Addr_OUT,
    input  logic        Mem_Ack_IN,
    input  logic [31:0] Mem_Data_IN,
    output logic        Instr_Valid_OUT,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4_OUT,
    output logic        Branch_prediction_OUT,
    output logic [1:0]  Branch_predictions_OUT,
    input  logic        Bht_Update_IN,
    input  logic [31:0] Bht_Update_PC_IN,
    input  logic        Bht_Taken_IN
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q;
    logic         req_q;
    logic [31:0]  addr_q;

    fetch_entry_t   q_mem [DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count_q;

    logic         pop, push, issue;
    logic         pred;
    logic [1:0]   ctr;
    logic [31:0]  pc4, next_pc;
    fetch_entry_t head, new_entry;

    assign pc4   = pc_q + 32'd4;
    assign pop   = !STALL && (count_q != '0) && !FLUSH;
    assign push  = (state_q == ST_WAIT) && Mem_Ack_IN && !FLUSH;
    // Credit is judged after this cycle's pop; nothing is in flight in IDLE.
    assign issue = (state_q == ST_IDLE) && !FLUSH &&
                   ((count_q - CW'(pop)) < CW'(DEPTH));

`ifdef FETCH_BHT_EN
    logic [1:0] bht_ctr;
    logic       unused_bht;

    fetch_bht #(.BHT_BITS(BHT_BITS)) u_bht (
        .CLK        (CLK),
        .RESET      (RESET),
        .lookup_idx (pc_q[BHT_BITS+1:2]),
        .update_en  (Bht_Update_IN),
        .update_idx (Bht_Update_PC_IN[BHT_BITS+1:2]),
        .taken      (Bht_Taken_IN),
        .lookup_ctr (bht_ctr)
    );

    assign ctr     = is_cond_branch(Mem_Data_IN) ? bht_ctr : 2'b00;
    assign pred    = ctr[1];
    assign next_pc = pred ? pc4 + {{14{Mem_Data_IN[15]}},
                                   Mem_Data_IN[15:0], 2'b00}
                          : pc4;
    assign unused_bht = ^{Bht_Update_PC_IN[31:BHT_BITS+2],
                          Bht_Update_PC_IN[1:0]};
`else
    logic unused_bht;

    assign ctr        = 2'b00;
    assign pred       = 1'b0;
    assign next_pc    = pc4;
    assign unused_bht = ^{Bht_Update_IN, Bht_Update_PC_IN,
                          Bht_Taken_IN, (BHT_BITS > 0)};
`endif

    assign new_entry = '{instr: Mem_Data_IN, pc: pc_q, pc4: pc4,
                         pred: pred, ctr: ctr};

    assign head = (count_q != '0) ? q_mem[rd_ptr] : '0;

    assign Instr_Valid_OUT        = (count_q != '0);
    assign Instr1_OUT             = head.instr;
    assign Instr_PC_OUT           = head.pc;
    assign Instr_PC_Plus4_OUT     = head.pc4;
    assign Branch_prediction_OUT  = head.pred;
    assign Branch_predictions_OUT = head.ctr;
    assign Mem_Req_OUT            = req_q;
    assign Mem_Addr_OUT           = addr_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (issue) state_d = ST_WAIT;
            ST_WAIT: begin
                if (Mem_Ack_IN)  state_d = ST_IDLE;
                else if (FLUSH)  state_d = ST_DROP;
            end
            // An ack during DROP retires the stale request even under FLUSH.
            ST_DROP: if (Mem_Ack_IN) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= issue;
            if (issue) addr_q <= pc_q;
            if (FLUSH)      pc_q <= Redirect_Addr_IN;
            else if (push)  pc_q <= next_pc;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (FLUSH) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) q_mem[wr_ptr] <= new_entry;
    end

endmodule
